l2cache_fill_unit: RTL
======================

Name: l2cache_fill_unit

Overview:
Miss-service engine for the 2-way L2 cache. It is the write side of the L2 tag/data arrays, the counterpart to the tag-lookup comparator.
On an L2 miss it latches the request and victim-way state, writes back the victim line if it is dirty, and fetches the missing line from physical memory. It then issues a single array-write strobe that installs the new tag, data, valid=1 and dirty=0 into the victim way, and pulses done so the L2 controller can replay the lookup.

Parameters:
TAG_WIDTH, 23, tag bits per line
INDEX_WIDTH, 4, set-index bits (16 sets)
OFFSET_WIDTH, 5, byte-offset bits (32-byte line); TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH must equal 32
LINE_WIDTH, 256, bits per cache line

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
miss_req  in  1  L2 lookup missed; sampled only in IDLE
miss_addr  in  32  address of missing access
victim_way  in  1  way chosen for replacement (LRU)
victim_valid  in  1  valid bit of victim way at miss_addr index
victim_dirty  in  1  dirty bit of victim way
victim_tag  in  TAG_WIDTH  tag stored in victim way
victim_data  in  LINE_WIDTH  line stored in victim way
pmem_resp  in  1  memory transaction complete
pmem_rdata  in  LINE_WIDTH  read data, valid when pmem_resp=1 during FETCH
pmem_read  out  1  memory read request
pmem_write  out  1  memory write request
pmem_address  out  32  line-aligned memory address
pmem_wdata  out  LINE_WIDTH  writeback data
fill_we  out  1  array write strobe
fill_way  out  1  way to write
fill_index  out  INDEX_WIDTH  set to write
fill_tag  out  TAG_WIDTH  tag to install
fill_data  out  LINE_WIDTH  line to install
fill_valid  out  1  valid bit to install (1 while fill_we)
fill_dirty  out  1  dirty bit to install (always 0)
fill_done  out  1  one-cycle completion pulse
busy  out  1  high in every state except IDLE

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- States: IDLE, WRITEBACK, FETCH, INSTALL, DONE. Outputs are Moore-decoded from state plus latched registers.
- Reset: state=IDLE. All latched registers cleared to 0. All strobes (pmem_read, pmem_write, fill_we, fill_done, busy) are 0 in the cycle after the reset edge.
- Reset mid-operation aborts any transaction. Memory-side strobes drop at that edge. There is no partial array write.
- IDLE: on miss_req=1 the block latches:
  - tag=miss_addr[31:32-TAG_WIDTH] and index=miss_addr[OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH]
  - victim_way, victim_tag, victim_data
  - wb_needed = victim_valid & victim_dirty
  Next state is WRITEBACK if wb_needed, else FETCH.
- WRITEBACK: pmem_write=1, pmem_address={victim_tag_l, index_l, OFFSET_WIDTH'b0}, pmem_wdata=victim_data_l. These are held stable until pmem_resp=1, then FETCH.
- FETCH: pmem_read=1, pmem_address={tag_l, index_l, OFFSET_WIDTH'b0}, held until pmem_resp=1. On that edge pmem_rdata is captured into line_l, then INSTALL.
- INSTALL: fill_we=1 for exactly one cycle, with:
  - fill_way=way_l, fill_index=index_l, fill_tag=tag_l, fill_data=line_l
  - fill_valid=1, fill_dirty=0
  Next state is DONE.
- DONE: fill_done=1 for exactly one cycle, then IDLE.
- pmem_read and pmem_write are never high together.
- pmem_resp is ignored in IDLE, INSTALL and DONE.
- miss_req is ignored while busy=1.
- miss_req held high through DONE starts a new miss on the first IDLE cycle after DONE.
- Outside WRITEBACK/FETCH: pmem_address=0, pmem_wdata=0. Outside INSTALL: fill_* data outputs are don't-care but driven (no X), fill_we=0.
- Latency, clean miss:
  - miss_req sampled at edge 0.
  - FETCH occupies cycles 1..k, with pmem_resp=1 in cycle k.
  - fill_we is high in cycle k+1; fill_done is high in cycle k+2.
- Latency, dirty miss: the WRITEBACK cycles are inserted before FETCH.

Test Plan:
- Clean miss: miss_addr=0x1234_5660, victim_valid=1, victim_dirty=0, victim_way=1, pmem_resp after 3 cycles with rdata=256'hA5 -> no pmem_write; pmem_read with address 0x1234_5660; then one fill_we cycle with way=1, index=0x3, tag=0x091A2B, data=256'hA5, valid=1, dirty=0; then one fill_done cycle.
- Dirty miss: victim_valid=1, victim_dirty=1, victim_tag=0x7FFFFF, index=0xF, victim_data=256'h1 -> pmem_write with address 0xFFFF_FFE0 and wdata 256'h1 until resp; then pmem_read of the new address; then fill.
- Invalid-but-dirty victim (valid=0, dirty=1) -> no writeback; goes straight to FETCH.
- Reset asserted for one cycle mid-FETCH -> next cycle pmem_read=0, busy=0, fill_we never pulses; a subsequent miss completes normally.
- miss_req toggled during WRITEBACK with a different address, plus a spurious pmem_resp in IDLE -> the original request completes unchanged, and the stray resp causes no state change.
- Back-to-back: miss_req held high across DONE -> second miss begins on the cycle after fill_done, using the newly sampled inputs.

Source files
------------

// File: rtl/l2cache_fill_unit.sv
// Miss-service engine for the 2-way L2 cache: writes back a dirty victim, fetches
// the missing line from physical memory, installs it with one array-write strobe.
module l2cache_fill_unit #(
    parameter int TAG_WIDTH    = 23,
    parameter int INDEX_WIDTH  = 4,
    parameter int OFFSET_WIDTH = 5,
    parameter int LINE_WIDTH   = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   miss_req,
    input  logic [31:0]            miss_addr,
    input  logic                   victim_way,
    input  logic                   victim_valid,
    input  logic                   victim_dirty,
    input  logic [TAG_WIDTH-1:0]   victim_tag,
    input  logic [LINE_WIDTH-1:0]  victim_data,
    input  logic                   pmem_resp,
    input  logic [LINE_WIDTH-1:0]  pmem_rdata,
    output logic                   pmem_read,
    output logic                   pmem_write,
    output logic [31:0]            pmem_address,
    output logic [LINE_WIDTH-1:0]  pmem_wdata,
    output logic                   fill_we,
    output logic                   fill_way,
    output logic [INDEX_WIDTH-1:0] fill_index,
    output logic [TAG_WIDTH-1:0]   fill_tag,
    output logic [LINE_WIDTH-1:0]  fill_data,
    output logic                   fill_valid,
    output logic                   fill_dirty,
    output logic                   fill_done,
    output logic                   busy
);

    typedef enum logic [2:0] {
        IDLE,
        WRITEBACK,
        FETCH,
        INSTALL,
        DONE
    } state_t;

    state_t                 state;
    logic [TAG_WIDTH-1:0]   tag_l;
    logic [INDEX_WIDTH-1:0] index_l;
    logic                   way_l;

    logic [TAG_WIDTH-1:0]   miss_tag;
    logic [INDEX_WIDTH-1:0] miss_index;
    logic                   unused_offset;

    assign miss_tag      = miss_addr[31:32-TAG_WIDTH];
    assign miss_index    = miss_addr[OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH];
    assign unused_offset = ^miss_addr[OFFSET_WIDTH-1:0];

    // The fill port reflects the latched request; only the strobe gates the write.
    assign fill_way   = way_l;
    assign fill_index = index_l;
    assign fill_tag   = tag_l;
    assign fill_valid = fill_we;
    assign fill_dirty = 1'b0;

    // pmem_wdata doubles as the latched victim line and fill_data as the fetched
    // line, so no separate copies are kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the line-wide registers are cleared too so no X ever reaches
            // the memory or array ports after reset, at the cost of a wide reset.
            state        <= IDLE;
            tag_l        <= '0;
            index_l      <= '0;
            way_l        <= 1'b0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            fill_we      <= 1'b0;
            fill_data    <= '0;
            fill_done    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees the
            // pre-edge register values regardless of statement order.
            fill_we   <= 1'b0;
            fill_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (miss_req) begin
                        tag_l   <= miss_tag;
                        index_l <= miss_index;
                        way_l   <= victim_way;
                        busy    <= 1'b1;
                        if (victim_valid && victim_dirty) begin
                            state        <= WRITEBACK;
                            pmem_write   <= 1'b1;
                            pmem_address <= {victim_tag, miss_index, {OFFSET_WIDTH{1'b0}}};
                            pmem_wdata   <= victim_data;
                        end else begin
                            state        <= FETCH;
                            pmem_read    <= 1'b1;
                            pmem_address <= {miss_tag, miss_index, {OFFSET_WIDTH{1'b0}}};
                        end
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        state        <= FETCH;
                        pmem_write   <= 1'b0;
                        pmem_wdata   <= '0;
                        pmem_read    <= 1'b1;
                        pmem_address <= {tag_l, index_l, {OFFSET_WIDTH{1'b0}}};
                    end
                end
                FETCH: begin
                    if (pmem_resp) begin
                        state        <= INSTALL;
                        pmem_read    <= 1'b0;
                        pmem_address <= '0;
                        fill_data    <= pmem_rdata;
                        fill_we      <= 1'b1;
                    end
                end
                INSTALL: begin
                    state     <= DONE;
                    fill_done <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
